// File: rtl/clock_time_set_controller.sv
// MM:SS time register with RUN / SET_MIN / SET_SEC modes and a blink mask for the field being edited.
// Both time fields are held as packed BCD pairs {tens, ones}.
//   state   | meaning
//   RUN     | counts on tick, btn_inc ignored, all digits lit
//   SET_MIN | time frozen, btn_inc bumps minutes, minute digits blink
//   SET_SEC | time frozen, btn_inc bumps seconds, second digits blink
module clock_time_set_controller #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] seg3,
  output logic [3:0] seg2,
  output logic [3:0] seg1,
  output logic [3:0] seg0,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       rollover
);

  localparam int CW = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } mode_t;

  mode_t         state, state_nx;
  logic [7:0]    min_q, min_nx;
  logic [7:0]    sec_q, sec_nx;
  logic          roll_q, roll_nx;
  logic [CW-1:0] blink_cnt, blink_cnt_nx;
  logic          phase_off, phase_off_nx;
  logic          restart;

  // Wraps 59 -> 00; the carry out is detected by the caller comparing against 8'h59.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_nx     = state;
    min_nx       = min_q;
    sec_nx       = sec_q;
    roll_nx      = 1'b0;
    blink_cnt_nx = blink_cnt;
    phase_off_nx = phase_off;
    restart      = 1'b0;

    case (state)
      RUN: begin
        if (tick) begin
          sec_nx = bcd_inc(sec_q);
          if (sec_q == 8'h59) begin
            min_nx  = bcd_inc(min_q);
            roll_nx = (min_q == 8'h59);
          end
        end
        if (btn_mode) state_nx = SET_MIN;
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_nx = SET_SEC;
        end else if (btn_inc) begin
          min_nx  = bcd_inc(min_q);
          restart = 1'b1;
        end
      end
      SET_SEC: begin
        if (btn_mode) begin
          state_nx = RUN;
        end else if (btn_inc) begin
          sec_nx  = bcd_inc(sec_q);
          restart = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase

    // Any press or mode change relights the edited digits immediately.
    if (restart || (state_nx != state) || (state == RUN)) begin
      blink_cnt_nx = '0;
      phase_off_nx = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nx = '0;
      phase_off_nx = ~phase_off;
    end else begin
      blink_cnt_nx = blink_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      roll_q    <= 1'b0;
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else begin
      state     <= state_nx;
      min_q     <= min_nx;
      sec_q     <= sec_nx;
      roll_q    <= roll_nx;
      blink_cnt <= blink_cnt_nx;
      phase_off <= phase_off_nx;
    end
  end

  always_comb begin
    blank = 4'b0000;
    case (state)
      SET_MIN: blank = {phase_off, phase_off, 2'b00};
      SET_SEC: blank = {2'b00, phase_off, phase_off};
      default: blank = 4'b0000;
    endcase
  end

  assign seg3     = min_q[7:4];
  assign seg2     = min_q[3:0];
  assign seg1     = sec_q[7:4];
  assign seg0     = sec_q[3:0];
  assign mode     = state;
  assign rollover = roll_q;

endmodule

// File: tb/tb_clock_time_set_controller.sv
// Bench for clock_time_set_controller: hand-written vector table plus a seconds-based reference model feeding a scoreboard.
module tb_clock_time_set_controller;
  localparam int BC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] seg3, seg2, seg1, seg0, blank;
  logic [1:0] mode;
  logic       rollover;

  clock_time_set_controller #(.BLINK_CYCLES(BC)) dut (
    .clock(clock), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
    .blank(blank), .mode(mode), .rollover(rollover)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] s3, s2, s1, s0;
    logic [3:0] blank;
    logic [1:0] mode;
    logic       roll;
  } obs_t;

  typedef struct {
    logic t, bm, bi;
    obs_t exp;
  } vec_t;

  obs_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   roll_seen = 0;

  // Reference model: time as seconds since 00:00, blink as edges since the last restart.
  int   m_time, m_mode, m_e;
  logic m_roll;

  function automatic obs_t model_obs();
    obs_t o;
    int mins, secs;
    logic dark;
    mins = m_time / 60;
    secs = m_time % 60;
    dark = ((m_e / BC) % 2) == 1;
    o.s3 = 4'(mins / 10);
    o.s2 = 4'(mins % 10);
    o.s1 = 4'(secs / 10);
    o.s0 = 4'(secs % 10);
    o.mode = 2'(m_mode);
    o.roll = m_roll;
    if (m_mode == 1)      o.blank = {dark, dark, 2'b00};
    else if (m_mode == 2) o.blank = {2'b00, dark, dark};
    else                  o.blank = 4'b0000;
    return o;
  endfunction

  function automatic void model_reset();
    m_time = 0; m_mode = 0; m_e = 0; m_roll = 1'b0;
  endfunction

  function automatic void model_step(input logic t, input logic bm, input logic bi);
    m_roll = 1'b0;
    case (m_mode)
      0: begin
        if (t) begin
          if (m_time == 3599) begin m_time = 0; m_roll = 1'b1; end
          else m_time = m_time + 1;
        end
        if (bm) m_mode = 1;
        m_e = 0;
      end
      1: begin
        if (bm) begin m_mode = 2; m_e = 0; end
        else if (bi) begin m_time = (((m_time / 60) + 1) % 60) * 60 + (m_time % 60); m_e = 0; end
        else m_e = m_e + 1;
      end
      default: begin
        if (bm) begin m_mode = 0; m_e = 0; end
        else if (bi) begin m_time = (m_time / 60) * 60 + ((m_time % 60) + 1) % 60; m_e = 0; end
        else m_e = m_e + 1;
      end
    endcase
  endfunction

  task automatic check(input string name);
    obs_t a, e;
    a = {seg3, seg2, seg1, seg0, blank, mode, rollover};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h (s3 s2 s1 s0 blank mode roll)", name, a, e);
      end
    end
  endtask

  task automatic drive_sample(input logic t, input logic bm, input logic bi, input string name);
    @(negedge clock);
    tick = t; btn_mode = bm; btn_inc = bi;
    @(posedge clock);
    #1;
    if (rollover) roll_seen++;
    check(name);
  endtask

  task automatic step(input logic t, input logic bm, input logic bi, input string name);
    model_step(t, bm, bi);
    sb.push_back(model_obs());
    drive_sample(t, bm, bi, name);
  endtask

  task automatic do_reset();
    @(negedge clock);
    tick = 0; btn_mode = 0; btn_inc = 0;
    reset = 1'b0;
    model_reset();
    #1;
    sb.push_back(model_obs());
    check("reset_state");
    @(negedge clock);
    reset = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    model_reset();
    // {tick, btn_mode, btn_inc} -> {s3,s2,s1,s0, blank, mode, roll}
    vecs[0] = '{1, 0, 0, '{4'd0, 4'd0, 4'd0, 4'd1, 4'b0000, 2'b00, 1'b0}};
    vecs[1] = '{0, 0, 1, '{4'd0, 4'd0, 4'd0, 4'd1, 4'b0000, 2'b00, 1'b0}};
    vecs[2] = '{1, 1, 0, '{4'd0, 4'd0, 4'd0, 4'd2, 4'b0000, 2'b01, 1'b0}};
    vecs[3] = '{0, 0, 1, '{4'd0, 4'd1, 4'd0, 4'd2, 4'b0000, 2'b01, 1'b0}};
    vecs[4] = '{1, 0, 0, '{4'd0, 4'd1, 4'd0, 4'd2, 4'b0000, 2'b01, 1'b0}};
    vecs[5] = '{0, 1, 1, '{4'd0, 4'd1, 4'd0, 4'd2, 4'b0000, 2'b10, 1'b0}};
    vecs[6] = '{0, 0, 1, '{4'd0, 4'd1, 4'd0, 4'd3, 4'b0000, 2'b10, 1'b0}};
    vecs[7] = '{1, 1, 0, '{4'd0, 4'd1, 4'd0, 4'd3, 4'b0000, 2'b00, 1'b0}};
    vecs[8] = '{1, 0, 0, '{4'd0, 4'd1, 4'd0, 4'd4, 4'b0000, 2'b00, 1'b0}};
    vecs[9] = '{0, 0, 1, '{4'd0, 4'd1, 4'd0, 4'd4, 4'b0000, 2'b00, 1'b0}};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      model_step(vecs[i].t, vecs[i].bm, vecs[i].bi);
      sb.push_back(vecs[i].exp);
      drive_sample(vecs[i].t, vecs[i].bm, vecs[i].bi, $sformatf("vec%0d", i));
    end

    // 3661 ticks from 00:00 -> 01:01 with one rollover after tick 3600
    do_reset();
    roll_seen = 0;
    for (int i = 0; i < 3661; i++) begin
      step(1, 0, 0, "run_tick");
      step(0, 0, 0, "run_idle");
    end
    total++;
    if ({seg3, seg2, seg1, seg0} !== 16'h0101) begin
      bad++;
      $display("FAIL digits_0101: got %h want 0101", {seg3, seg2, seg1, seg0});
    end
    total++;
    if (roll_seen != 1) begin
      bad++;
      $display("FAIL rollover_count_3661: got %0d want 1", roll_seen);
    end

    // Preload 59:58 through the SET modes, then two ticks roll over
    step(0, 1, 0, "enter_set_min");
    for (int i = 0; i < 58; i++) step(0, 0, 1, "inc_min");
    step(0, 1, 0, "enter_set_sec");
    for (int i = 0; i < 57; i++) step(0, 0, 1, "inc_sec");
    step(0, 1, 0, "back_to_run");
    roll_seen = 0;
    step(1, 0, 0, "tick_5959");
    step(1, 0, 0, "tick_rollover");
    step(0, 0, 0, "roll_clear");
    step(0, 0, 0, "roll_clear2");
    total++;
    if (roll_seen != 1) begin
      bad++;
      $display("FAIL rollover_once: got %0d want 1", roll_seen);
    end

    // SET_MIN: 61 increments with 100 ignored ticks interleaved
    roll_seen = 0;
    step(0, 1, 0, "to_set_min");
    for (int i = 0; i < 100; i++) begin
      if (i < 61) step(0, 0, 1, "min_inc61");
      step(1, 0, 0, "min_tick_ignored");
    end
    total++;
    if ({seg3, seg2, seg1, seg0, roll_seen[3:0]} !== {16'h0100, 4'd0}) begin
      bad++;
      $display("FAIL set_min_61: got %h rolls %0d want 0100 rolls 0", {seg3, seg2, seg1, seg0}, roll_seen);
    end

    // SET_SEC blink: visible 4, dark 4, then a press mid-dark relights
    step(0, 1, 0, "to_set_sec");
    for (int i = 0; i < 13; i++) step(0, 0, 0, "blink_idle");
    step(0, 0, 1, "inc_mid_dark");
    for (int i = 0; i < 6; i++) step(0, 0, 0, "blink_after_inc");

    // Same-cycle btn_mode & btn_inc in SET_MIN at 10:00
    do_reset();
    step(0, 1, 0, "sm_enter");
    for (int i = 0; i < 10; i++) step(0, 0, 1, "sm_inc");
    step(0, 1, 1, "mode_and_inc");

    // Same-cycle tick & btn_mode in RUN at 00:05
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, "to_0005");
    step(1, 1, 0, "tick_and_mode");
    total++;
    if ({seg3, seg2, seg1, seg0, mode} !== {16'h0006, 2'b01}) begin
      bad++;
      $display("FAIL tick_mode_0006: got %h mode %b want 0006 mode 01", {seg3, seg2, seg1, seg0}, mode);
    end

    // Asynchronous reset mid SET_SEC at 12:34
    do_reset();
    step(0, 1, 0, "ar_min");
    for (int i = 0; i < 12; i++) step(0, 0, 1, "ar_inc_min");
    step(0, 1, 0, "ar_sec");
    for (int i = 0; i < 34; i++) step(0, 0, 1, "ar_inc_sec");
    step(0, 0, 0, "ar_hold_1234");
    @(posedge clock);
    #2;
    tick = 0; btn_mode = 0; btn_inc = 0;
    reset = 1'b0;
    model_reset();
    sb.push_back(model_obs());
    #1;
    check("async_reset_mid_edit");
    @(negedge clock);
    reset = 1'b1;
    step(1, 0, 0, "after_async_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
